// File: rtl/md_pkg.sv
// Shared encodings and sizing for the multiply/divide unit.
// Latency: n/a (types, constants and a sizing helper only).
// Backpressure: n/a.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // The counter is loaded with latency-1, so clog2(latency) bits suffice;
  // never go below one bit so a latency of 1 or 2 still has a counter.
  function automatic int md_cnt_w(input int max_lat);
    return (max_lat <= 2) ? 1 : $clog2(max_lat);
  endfunction

  localparam int MD_CNT_W = md_cnt_w((MD_MULT_CYCLES_DEF > MD_DIV_CYCLES_DEF) ?
                                     MD_MULT_CYCLES_DEF : MD_DIV_CYCLES_DEF);

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the HI/LO results for one op.
// Latency: 0 cycles (pure combinational); the caller holds operands stable.
// Backpressure: none; outputs follow inputs.
// Ports: op (md_op encoding), a/b operands in; hi_res/lo_res results and
//        div_zero (divide op with zero divisor) out.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_div;
  logic        is_sdiv;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    prod_u = {32'd0, a} * {32'd0, b};
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  end

  // Signed division is done on magnitudes and the signs are reapplied.
  // This gives truncation toward zero, a remainder carrying the dividend's
  // sign, and makes 0x80000000 / -1 wrap to 0x80000000 with remainder 0.
  always_comb begin
    is_div   = (md_op_e'(op) == MD_DIV) || (md_op_e'(op) == MD_DIVU);
    is_sdiv  = (md_op_e'(op) == MD_DIV);
    a_mag    = (is_sdiv && a[31]) ? (~a + 32'd1) : a;
    b_mag    = (is_sdiv && b[31]) ? (~b + 32'd1) : b;
    // Keeps the divider defined on a zero divisor; the result is discarded.
    b_safe   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (is_sdiv && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    rem      = (is_sdiv && a[31]) ? (~r_mag + 32'd1) : r_mag;
    div_zero = is_div && (b == 32'd0);
  end

  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (md_op_e'(op))
      MD_MULT: begin
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
      end
      MD_MULTU: begin
        hi_res = prod_u[63:32];
        lo_res = prod_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        hi_res = rem;
        lo_res = quot;
      end
      default: begin
        hi_res = 32'd0;
        lo_res = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Latency: busy high MULT_CYCLES (mult) or DIV_CYCLES (div) cycles; MTHI/MTLO land next edge.
// Backpressure: none; start is ignored while busy, the hazard logic must stall on busy.
// Ports: clk, reset (async active-low), start/md_op/a/b request in;
//        busy, hi_out, lo_out out.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int CNT_W = md_cnt_w((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state;
  md_state_e        next_state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;

  logic             is_md_op;
  logic             launch;
  logic             mthi_we;
  logic             mtlo_we;
  logic             last_cycle;
  logic             commit;

  logic [31:0]      hi_res;
  logic [31:0]      lo_res;
  logic             div_zero;

  // Results come only from the latched operands so live a/b may change mid-run.
  md_calc u_calc (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  assign is_md_op   = (md_op[2] == 1'b0);   // encodings 0..3
  assign last_cycle = (cnt == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start && is_md_op) next_state = ST_RUN;
      ST_RUN:  if (last_cycle)        next_state = ST_IDLE;
      default:                        next_state = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy    = (state == ST_RUN);
    launch  = (state == ST_IDLE) && start && is_md_op;
    mthi_we = (state == ST_IDLE) && start && (md_op_e'(md_op) == MD_MTHI);
    mtlo_we = (state == ST_IDLE) && start && (md_op_e'(md_op) == MD_MTLO);
    // A zero divisor still burns the full latency but leaves HI/LO alone.
    commit  = (state == ST_RUN) && last_cycle && !div_zero;
  end

  // Operand latches and latency counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      op_q <= 3'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (launch) begin
      cnt  <= md_op[1] ? DIV_LOAD : MULT_LOAD;
      op_q <= md_op;
      a_q  <= a;
      b_q  <= b;
    end else if (busy && !last_cycle) begin
      cnt  <= cnt - 1'b1;
    end
  end

  // Architectural HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_out <= 32'd0;
      lo_out <= 32'd0;
    end else if (commit) begin
      hi_out <= hi_res;
      lo_out <= lo_res;
    end else begin
      if (mthi_we) hi_out <= a;
      if (mtlo_we) lo_out <= a;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: scoreboard of expected MULT/DIV results
// popped by a monitor at each busy falling edge, plus direct MT/no-op/reset checks.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd6;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_pass   = 0;
  int   n_total  = 0;
  int   n_done   = 0;
  int   n_pushed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: measures each busy window, checks HI/LO held during it, and
  // compares the committed result against the oldest scoreboard entry.
  int          mon_len  = 0;
  logic        mon_run  = 1'b0;
  logic        mon_held = 1'b1;
  logic [31:0] mon_hi0  = 32'd0;
  logic [31:0] mon_lo0  = 32'd0;
  exp_t        mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_run = 1'b0;
        mon_len = 0;
      end else if (busy) begin
        if (!mon_run) begin
          mon_run  = 1'b1;
          mon_len  = 0;
          mon_hi0  = hi_out;
          mon_lo0  = lo_out;
          mon_held = 1'b1;
        end
        mon_len++;
        if (hi_out !== mon_hi0 || lo_out !== mon_lo0) mon_held = 1'b0;
      end else if (mon_run) begin
        mon_run = 1'b0;
        n_done++;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_completion: got a busy window, expected none pending");
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, " busy_cycles"}, 32'(mon_len), 32'(mon_e.cyc));
          chk({mon_e.name, " hi"}, hi_out, mon_e.hi);
          chk({mon_e.name, " lo"}, lo_out, mon_e.lo);
          chk({mon_e.name, " hilo_held_while_busy"}, {31'd0, mon_held}, 32'd1);
        end
      end
    end
  end

  // One-cycle start pulse, sampled by the DUT at the second posedge.
  task automatic drive(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd6;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    bit done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (!busy) done = 1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s timeout: busy still 1 after 40 cycles, expected 0", name);
    end
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
    sb.push_back('{name, ehi, elo, cyc});
    n_pushed++;
    drive(op, av, bv);
    wait_idle(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi_out, 32'd0);
    chk("reset lo", lo_out, 32'd0);

    // Multiplies
    run_op("mult_neg",     3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_op("multu_max",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    run_op("multu_nosign", 3'd1, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 5);
    run_op("mult_minmin",  3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5);

    // Divides
    run_op("div_neg_dividend", 3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("div_neg_divisor",  3'd2, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    run_op("divu",             3'd3, 32'd7,        32'd2,        32'h0000_0001, 32'h0000_0003, 10);
    run_op("div_overflow",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);

    // MTHI/MTLO, divide by zero, no-ops
    drive(3'd4, 32'h0000_1234, 32'hAAAA_AAAA);
    @(negedge clk);
    chk("mthi hi", hi_out, 32'h0000_1234);
    chk("mthi lo_unchanged", lo_out, 32'h8000_0000);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    drive(3'd5, 32'h0000_5678, 32'h5555_5555);
    @(negedge clk);
    chk("mtlo lo", lo_out, 32'h0000_5678);
    chk("mtlo hi_unchanged", hi_out, 32'h0000_1234);
    run_op("divu_by_zero", 3'd3, 32'd9, 32'd0, 32'h0000_1234, 32'h0000_5678, 10);
    run_op("div_by_zero",  3'd2, 32'hFFFF_FFF0, 32'd0, 32'h0000_1234, 32'h0000_5678, 10);
    drive(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("nop6 busy", {31'd0, busy}, 32'd0);
    chk("nop6 hi", hi_out, 32'h0000_1234);
    chk("nop6 lo", lo_out, 32'h0000_5678);
    drive(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("nop7 busy", {31'd0, busy}, 32'd0);
    chk("nop7 lo", lo_out, 32'h0000_5678);

    // Overlapping starts are ignored and live operands do not leak in
    sb.push_back('{"mult_overlap", 32'h0000_0001, 32'h0000_0000, 5});
    n_pushed++;
    drive(3'd0, 32'h0001_0000, 32'h0001_0000);
    drive(3'd5, 32'h0000_DEAD, 32'd0);
    drive(3'd2, 32'd100, 32'd7);
    a = 32'h1357_9BDF;
    b = 32'h0246_8ACE;
    wait_idle("mult_overlap");
    chk("overlap busy_after", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a divide
    drive(3'd5, 32'h0000_0055, 32'd0);
    drive(3'd2, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_reset busy", {31'd0, busy}, 32'd0);
    chk("async_reset hi", hi_out, 32'd0);
    chk("async_reset lo", lo_out, 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    chk("post_reset busy", {31'd0, busy}, 32'd0);
    run_op("mult_after_reset", 3'd0, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A, 5);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    chk("completion count", 32'(n_done), 32'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
